// File: rtl/dmem_pkg.sv
// Shared types for the parameterised data memory: access size encoding, controller
// states and a constant clog2 helper. The DUMP state exists only when DMEM_DUMP_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

`ifdef DMEM_DUMP_EN
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_DUMP  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1
  } state_e;
`endif

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: positions store data and builds the byte mask, and
// extracts plus sign/zero-extends load data from a full memory word.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = 2
) (
  input  size_e              size,
  input  logic [OFF_W-1:0]   offset,
  input  logic               sign_ext,
  input  logic [DATA_W-1:0]  st_data,
  output logic [DATA_W/8-1:0] st_mask,
  output logic [DATA_W-1:0]  st_lanes,
  input  logic [DATA_W-1:0]  ld_word,
  output logic [DATA_W-1:0]  ld_data
);

  localparam int NB = DATA_W / 8;

  logic [OFF_W+2:0]  shamt;
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] keep;
  logic [NB-1:0]     base_mask;
  logic              sign_bit;

  always_comb begin
    shamt    = {offset, 3'b000};
    st_lanes = st_data << shamt;
    ld_shift = ld_word >> shamt;
    case (size)
      SZ_BYTE: begin
        base_mask = NB'(1);
        keep      = DATA_W'(8'hFF);
        sign_bit  = ld_shift[7];
      end
      SZ_HALF: begin
        base_mask = NB'(2'b11);
        keep      = DATA_W'(16'hFFFF);
        sign_bit  = ld_shift[15];
      end
      SZ_WORD: begin
        base_mask = NB'(4'hF);
        keep      = DATA_W'(32'hFFFF_FFFF);
        sign_bit  = ld_shift[31];
      end
      default: begin
        base_mask = '1;
        keep      = '1;
        sign_bit  = ld_shift[DATA_W-1];
      end
    endcase
    st_mask = base_mask << offset;
    ld_data = (ld_shift & keep) | ((sign_ext && sign_bit) ? ~keep : '0);
  end

endmodule

// File: rtl/param_data_memory.sv
// Byte-addressable data memory with self-clear after reset and a one-cycle response pipe.
// Optional sequential contents dump is built when DMEM_DUMP_EN is defined.
module param_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  localparam int WADDR_W = clog2(DEPTH),
  localparam int OFF_W   = clog2(DATA_W / 8),
  localparam int BADDR_W = WADDR_W + OFF_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [BADDR_W-1:0] req_addr,
  input  logic [1:0]         req_size,
  input  logic               req_signed,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  input  logic               dump_start,
  output logic               dump_valid,
  output logic [WADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0]  dump_data,
  output logic               busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [WADDR_W-1:0] LAST_IDX = WADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [WADDR_W-1:0] idx_q, idx_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic [OFF_W-1:0]   off;
  logic [WADDR_W-1:0] widx;
  logic               accept, misalign, size_err, range_err, err;
  logic [DATA_W-1:0]  rd_word, ld_data, st_lanes;
  logic [NB-1:0]      st_mask;

  logic               mem_we;
  logic [WADDR_W-1:0] mem_widx;
  logic [DATA_W-1:0]  mem_wdata;
  logic [NB-1:0]      mem_wmask;

  assign off     = req_addr[OFF_W-1:0];
  assign widx    = req_addr[BADDR_W-1:OFF_W];
  assign rd_word = range_err ? '0 : mem[widx];

  dmem_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .size     (size_e'(req_size)),
    .offset   (off),
    .sign_ext (req_signed),
    .st_data  (req_wdata),
    .st_mask  (st_mask),
    .st_lanes (st_lanes),
    .ld_word  (rd_word),
    .ld_data  (ld_data)
  );

  always_comb begin
    case (size_e'(req_size))
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = off[0];
      SZ_WORD: misalign = |off[1:0];
      default: misalign = |off;
    endcase
    size_err  = (size_e'(req_size) == SZ_DWORD) && (DATA_W == 32);
    range_err = int'(widx) >= DEPTH;
    err       = misalign | size_err | range_err;
    accept    = req_valid && (state_q == ST_IDLE);

    state_d   = state_q;
    idx_d     = idx_q;
    mem_we    = 1'b0;
    mem_widx  = widx;
    mem_wdata = st_lanes;
    mem_wmask = st_mask;

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_widx  = idx_q;
        mem_wdata = '0;
        mem_wmask = '1;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept && req_we && !err) mem_we = 1'b1;
`ifdef DMEM_DUMP_EN
        // A request on the same edge takes priority over a dump request.
        if (dump_start && !req_valid) begin
          idx_d   = '0;
          state_d = ST_DUMP;
        end
`endif
      end
`ifdef DMEM_DUMP_EN
      ST_DUMP: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`endif
      default: state_d = ST_CLEAR;
    endcase

    rsp_valid_d = accept;
    rsp_err_d   = accept && err;
    rsp_rdata_d = (accept && !req_we && !err) ? ld_data : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // NOTE: the array has no reset; the CLEAR sweep zeroes it, which keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_wmask[b]) mem[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef DMEM_DUMP_EN
  assign dump_valid = (state_q == ST_DUMP);
  assign dump_addr  = dump_valid ? idx_q : '0;
  assign dump_data  = dump_valid ? mem[idx_q] : '0;
`else
  logic unused_dump_start;
  assign unused_dump_start = dump_start;
  assign dump_valid = 1'b0;
  assign dump_addr  = '0;
  assign dump_data  = '0;
`endif

endmodule
